debug_uart_tx_queue: RTL

//  Byte queue and sequencer in front of the debug uart_tx. CPU writes to the debug UART data

---
 rtl/debug_uart_tx_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/debug_uart_tx_queue.sv
// debug_uart_tx_queue
//  Byte FIFO plus launch sequencer in front of the debug uart_tx. CPU writes are
//  queued and drained one byte at a time using the uart_tx_en / uart_tx_busy
//  handshake, so software does not have to poll per byte.
//
//  Optional build macro: DEBUG_UART_TXQ_STALL_EN
//   defined   : a write into a full queue (with no pop that cycle) raises
//               wr_stall so the bus holds the write; overflow never sets.
//   undefined : wr_stall is tied low; a write into a full queue is dropped
//               and sets the sticky overflow flag.
module debug_uart_tx_queue #(
   parameter  int DEPTH = 4,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          flush,
   input  logic          ovf_clr,
   input  logic          uart_tx_busy,
   output logic          uart_tx_en,
   output logic [7:0]    uart_tx_data,
   output logic          empty,
   output logic          full,
   output logic [LW-1:0] level,
   output logic          active,
   output logic          overflow,
   output logic          wr_stall
);

   localparam int AW = LW - 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LAUNCH    = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [1:0]    wait_cnt, wait_cnt_nx;
   logic [LW-1:0] wptr, rptr;
   logic [7:0]    mem [DEPTH];
   logic          launch;
   logic          push;
   logic          drop;

   // Pointer compare: equal pointers mean empty; differing only in the wrap bit
   // means full. Level is the modular pointer difference.
   assign empty  = (wptr == rptr);
   assign full   = (wptr[LW-1] != rptr[LW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign level  = wptr - rptr;
   assign active = !empty || (state != S_IDLE);

   // A launch is also the pop; flush suppresses it so a freshly discarded
   // head byte can never escape.
   assign launch = (state == S_IDLE) && !empty && !uart_tx_busy && !flush;

   // A push into a full queue is still accepted when the head leaves in the
   // same cycle; flush discards any concurrent write.
   assign push = wr_en && !flush && (!full || launch);

`ifdef DEBUG_UART_TXQ_STALL_EN
   assign drop     = 1'b0;
   assign wr_stall = full & wr_en & !launch;
`else
   assign drop     = wr_en && !flush && full && !launch;
   assign wr_stall = 1'b0;
`endif

   // Queue storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push)
         mem[wptr[AW-1:0]] <= wr_data;
   end

   // Read/write pointers; flush returns both to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (launch)
            rptr <= rptr + 1'b1;
      end
   end

   // Sticky overflow; a new drop wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
      else if (ovf_clr)
         overflow <= 1'b0;
   end

   // Registered launch pulse and byte towards uart_tx; data holds between launches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uart_tx_en   <= 1'b0;
         uart_tx_data <= 8'h00;
      end else begin
         uart_tx_en <= launch;
         if (launch)
            uart_tx_data <= mem[rptr[AW-1:0]];
      end
   end

   // Sequencer state register and busy-wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         wait_cnt <= 2'd0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
      end
   end

   // Sequencer next state: launch, let uart_tx pick it up, then follow busy.
   // WAIT_BUSY gives up after four cycles so a lost launch cannot wedge the
   // queue; that byte is treated as sent.
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      case (state)
         S_IDLE: begin
            if (launch)
               state_nx = S_LAUNCH;
         end
         S_LAUNCH: begin
            state_nx    = S_WAIT_BUSY;
            wait_cnt_nx = 2'd0;
         end
         S_WAIT_BUSY: begin
            if (uart_tx_busy)
               state_nx = S_WAIT_DONE;
            else if (wait_cnt == 2'd3)
               state_nx = S_IDLE;
            else
               wait_cnt_nx = wait_cnt + 2'd1;
         end
         S_WAIT_DONE: begin
            if (!uart_tx_busy)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule
